// File: rtl/fifo_pkg.sv
// Shared sizing for the 32x8 FIFO and its storage.
// Defaults match the LIFO stack so either buffer fits the same datapath.
package fifo_pkg;

   localparam int FIFO_WIDTH   = 8;
   localparam int FIFO_DEPTH   = 32;
   localparam int FIFO_ADDR_W  = 5;
   localparam int FIFO_COUNT_W = FIFO_ADDR_W + 1;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH  = FIFO_WIDTH,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: storage is deliberately not reset; its contents are don't-care and a
   // reset would force the array into flops instead of a RAM macro.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // NOTE: non-blocking assignments here are what give old-data-on-collision:
   // the read samples mem_q before this edge's write lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : fifo_ram

// File: rtl/fifo_32x8.sv
// 32-entry x 8-bit in-order queue: pointers, occupancy count, flags and
// registered overflow/underflow pulses around a fifo_ram storage array.
module fifo_32x8
   import fifo_pkg::*;
#(
   parameter int WIDTH  = FIFO_WIDTH,
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              rd_ok;
   logic              wr_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + CNT_W'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= rd_ok;
         overflow_q  <= wr_en & full & ~rd_ok;
         underflow_q <= rd_en & empty;
      end
   end

   fifo_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_ok & ~reset),
      .waddr_i (wr_ptr_q),
      .wdata_i (in),
      .re_i    (rd_ok),
      .raddr_i (rd_ptr_q),
      .rdata_o (out)
   );

   assign out_valid = out_valid_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule : fifo_32x8

// File: tb/tb_fifo_32x8.sv
// Directed self-checking bench for fifo_32x8: reset, ordering, fill/wrap,
// simultaneous read/write at full and empty, and mid-operation reset.
module tb_fifo_32x8;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] dout;
   logic       out_valid;
   logic       empty;
   logic       full;
   logic [5:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   fifo_32x8 dut (
      .clk       (clk),
      .reset     (reset),
      .in        (din),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .out       (dout),
      .out_valid (out_valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1ns after it, inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
      tick(); tick();
      reset = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_out got=%h exp=00", dout); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
   endtask

   task automatic test_order();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; din = vals[i]; tick();
      end
      wr_en = 1'b0;
      checks++; if (count !== 6'd3) begin errors++; $display("FAIL order_count3 got=%0d exp=3", count); end
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1; tick();
         checks++; if (dout !== vals[i] || out_valid !== 1'b1) begin
            errors++; $display("FAIL order_read%0d got=%h/%b exp=%h/1", i, dout, out_valid, vals[i]);
         end
      end
      rd_en = 1'b0;
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL order_drained count=%0d empty=%b exp=0/1", count, empty); end
      tick();
      checks++; if (out_valid !== 1'b0 || dout !== 8'h33) begin errors++; $display("FAIL order_idle got=%h/%b exp=33/0", dout, out_valid); end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] exp;
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; din = 8'(i); tick();
      end
      checks++; if (full !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL fill_full full=%b count=%0d exp=1/32", full, count); end
      din = 8'hAA; tick();
      wr_en = 1'b0;
      checks++; if (overflow !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL fill_overflow ovf=%b count=%0d exp=1/32", overflow, count); end
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got=%b exp=0", overflow); end
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; tick();
         checks++; if (dout !== 8'(i) || out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_read_a%0d got=%h/%b exp=%h/1", i, dout, out_valid, 8'(i));
         end
      end
      rd_en = 1'b0;
      checks++; if (count !== 6'd16) begin errors++; $display("FAIL wrap_count16 got=%0d exp=16", count); end
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; din = 8'h80 + 8'(i); tick();
      end
      wr_en = 1'b0;
      checks++; if (full !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL wrap_refull full=%b count=%0d exp=1/32", full, count); end
      for (int i = 0; i < 32; i++) begin
         exp = (i < 16) ? 8'h10 + 8'(i) : 8'h80 + 8'(i - 16);
         rd_en = 1'b1; tick();
         checks++; if (dout !== exp || out_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_read_b%0d got=%h/%b exp=%h/1", i, dout, out_valid, exp);
         end
      end
      rd_en = 1'b0;
      checks++; if (empty !== 1'b1 || count !== 6'd0 || underflow !== 1'b0) begin
         errors++; $display("FAIL wrap_empty empty=%b count=%0d unf=%b exp=1/0/0", empty, count, underflow);
      end
   endtask

   task automatic test_full_simul();
      logic [7:0] exp;
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; din = 8'h60 + 8'(i); tick();
      end
      rd_en = 1'b1; din = 8'h55; tick();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (dout !== 8'h60 || out_valid !== 1'b1) begin errors++; $display("FAIL fullsim_head got=%h/%b exp=60/1", dout, out_valid); end
      checks++; if (count !== 6'd32 || full !== 1'b1 || overflow !== 1'b0) begin
         errors++; $display("FAIL fullsim_state count=%0d full=%b ovf=%b exp=32/1/0", count, full, overflow);
      end
      for (int i = 0; i < 32; i++) begin
         exp = (i < 31) ? 8'h61 + 8'(i) : 8'h55;
         rd_en = 1'b1; tick();
         checks++; if (dout !== exp || out_valid !== 1'b1) begin
            errors++; $display("FAIL fullsim_drain%0d got=%h/%b exp=%h/1", i, dout, out_valid, exp);
         end
      end
      rd_en = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullsim_empty got=%b exp=1", empty); end
   endtask

   task automatic test_empty_simul();
      rd_en = 1'b1; wr_en = 1'b1; din = 8'h77; tick();
      wr_en = 1'b0;
      checks++; if (underflow !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL emptysim_unf unf=%b valid=%b exp=1/0", underflow, out_valid); end
      checks++; if (count !== 6'd1 || empty !== 1'b0) begin errors++; $display("FAIL emptysim_count count=%0d empty=%b exp=1/0", count, empty); end
      checks++; if (dout !== 8'h55) begin errors++; $display("FAIL emptysim_hold got=%h exp=55", dout); end
      tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'h77 || out_valid !== 1'b1 || underflow !== 1'b0) begin
         errors++; $display("FAIL emptysim_read got=%h/%b unf=%b exp=77/1/0", dout, out_valid, underflow);
      end
      checks++; if (count !== 6'd0) begin errors++; $display("FAIL emptysim_count0 got=%0d exp=0", count); end
   endtask

   task automatic test_mid_reset();
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; din = 8'(i); tick();
      end
      wr_en = 1'b0;
      reset = 1'b1; rd_en = 1'b1; tick();
      reset = 1'b0; rd_en = 1'b0;
      checks++; if (out_valid !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL midrst_out got=%h/%b exp=00/0", dout, out_valid); end
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL midrst_state count=%0d empty=%b exp=0/1", count, empty); end
      wr_en = 1'b1; din = 8'h42; tick();
      wr_en = 1'b0; rd_en = 1'b1; tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'h42 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_data got=%h/%b exp=42/1", dout, out_valid); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_fill_wrap();
      test_full_simul();
      test_empty_simul();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_32x8
